// File: rtl/adc_capture_memctrl_pkg.sv
// Shared definitions for the ADC capture sequencer: command FSM states and
// the FIFO level at which queued writes pre-empt a pending host read.
package adc_capture_memctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD     = 2'd2,
    ST_RDWAIT = 2'd3
  } cmd_state_t;

  function automatic int unsigned fifo_half_level(input int unsigned abit);
    return 32'd1 << (abit - 32'd1);
  endfunction

endpackage

// File: rtl/adc_capture_memctrl_if.sv
// Internal memory write/read bus towards the Avalon bridge (inb_* signals).
// master drives commands; slave is the bridge side.
interface adc_capture_memctrl_if #(
  parameter int unsigned P_DATA_NBIT = 32,
  parameter int unsigned P_ADDR_NBIT = 16
);
  logic [P_ADDR_NBIT-1:0] address;
  logic                   write;
  logic [P_DATA_NBIT-1:0] wdata;
  logic                   read;
  logic [P_DATA_NBIT-1:0] rdata;
  logic                   datavalid;
  logic                   initdone;

  modport master (
    output address, write, wdata, read,
    input  rdata, datavalid, initdone
  );

  modport slave (
    input  address, write, wdata, read,
    output rdata, datavalid, initdone
  );
endinterface

// File: rtl/adc_capture_memctrl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: o_rdata always shows the head entry.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_ABIT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [P_WIDTH-1:0] i_wdata,
  output logic [P_WIDTH-1:0] o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [P_ABIT:0]    o_count
);
  localparam int unsigned LP_DEPTH = 32'd1 << P_ABIT;

  logic [P_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [P_ABIT-1:0]  r_wptr;
  logic [P_ABIT-1:0]  r_rptr;
  logic [P_ABIT:0]    r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == (P_ABIT+1)'(LP_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + P_ABIT'(1);
      if (w_pop)  r_rptr <= r_rptr + P_ABIT'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (P_ABIT+1)'(1);
        2'b01:   r_count <= r_count - (P_ABIT+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/adc_capture_memctrl.sv
// Buffers ADC samples and writes each capture to consecutive memory words over
// the inb_* bus; also serves single-word host readbacks on the same bus.
module adc_capture_memctrl
  import adc_capture_memctrl_pkg::*;
#(
  parameter int unsigned P_DATA_NBIT = 32,
  parameter int unsigned P_ADDR_NBIT = 16,
  parameter int unsigned P_FIFO_ABIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_start,
  input  logic [P_ADDR_NBIT-1:0] cap_base,
  input  logic [P_ADDR_NBIT-1:0] cap_len,
  input  logic                   smp_valid,
  input  logic [P_DATA_NBIT-1:0] smp_data,
  output logic                   cap_busy,
  output logic                   cap_done,
  output logic                   cap_ovf,
  input  logic                   rd_req,
  input  logic [P_ADDR_NBIT-1:0] rd_addr,
  output logic                   rd_busy,
  output logic [P_DATA_NBIT-1:0] rd_data,
  output logic                   rd_valid,
  adc_capture_memctrl_if.master  inb
);
  localparam int unsigned          LP_FW   = P_ADDR_NBIT + P_DATA_NBIT;
  localparam logic [P_FIFO_ABIT:0] LP_HALF = (P_FIFO_ABIT+1)'(fifo_half_level(P_FIFO_ABIT));

  cmd_state_t             r_state;
  // Address of the next incoming sample; FIFO entries carry their own address
  // so a dropped sample leaves a hole exactly at its position in the capture.
  logic [P_ADDR_NBIT-1:0] r_wr_addr;
  logic [P_ADDR_NBIT-1:0] r_acc_left;
  logic [P_ADDR_NBIT-1:0] r_wr_left;
  logic                   r_cap_busy;
  logic                   r_cap_done;
  logic                   r_cap_ovf;
  logic                   r_rd_busy;
  logic [P_ADDR_NBIT-1:0] r_rd_addr;
  logic [P_DATA_NBIT-1:0] r_rd_data;
  logic                   r_rd_valid;
  logic [P_ADDR_NBIT-1:0] r_inb_address;
  logic                   r_inb_write;
  logic [P_DATA_NBIT-1:0] r_inb_wdata;
  logic                   r_inb_read;

  logic                   w_cap_accept;
  logic                   w_smp_take;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic [P_ADDR_NBIT-1:0] w_wr_left_nxt;
  logic [LP_FW-1:0]       w_fifo_wdata;
  logic [LP_FW-1:0]       w_fifo_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [P_FIFO_ABIT:0]   w_fifo_count;

  assign w_cap_accept  = cap_start && !r_cap_busy;
  assign w_smp_take    = smp_valid && r_cap_busy && (r_acc_left != '0);
  assign w_push        = w_smp_take && !w_fifo_full;
  assign w_drop        = w_smp_take && w_fifo_full;
  assign w_pop         = (r_state == ST_WR) && inb.initdone;
  assign w_wr_left_nxt = r_wr_left - P_ADDR_NBIT'(w_pop) - P_ADDR_NBIT'(w_drop);
  assign w_fifo_wdata  = {r_wr_addr, smp_data};

  sync_fifo #(
    .P_WIDTH (LP_FW),
    .P_ABIT  (P_FIFO_ABIT)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_acc_left <= '0;
      r_wr_left  <= '0;
      r_cap_busy <= 1'b0;
      r_cap_done <= 1'b0;
      r_cap_ovf  <= 1'b0;
    end else begin
      r_cap_done <= 1'b0;
      if (w_cap_accept) begin
        r_wr_addr  <= cap_base;
        r_acc_left <= cap_len;
        r_wr_left  <= cap_len;
        r_cap_ovf  <= 1'b0;
        if (cap_len == '0) r_cap_done <= 1'b1;
        else               r_cap_busy <= 1'b1;
      end else if (r_cap_busy) begin
        if (w_smp_take) begin
          r_acc_left <= r_acc_left - P_ADDR_NBIT'(1);
          r_wr_addr  <= r_wr_addr + P_ADDR_NBIT'(1);
        end
        if (w_drop) r_cap_ovf <= 1'b1;
        // wr_left counts words neither written nor dropped yet
        r_wr_left <= w_wr_left_nxt;
        if (w_wr_left_nxt == '0) begin
          r_cap_busy <= 1'b0;
          r_cap_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rd_busy     <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_inb_address <= '0;
      r_inb_write   <= 1'b0;
      r_inb_wdata   <= '0;
      r_inb_read    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (rd_req && !r_rd_busy) begin
        r_rd_busy <= 1'b1;
        r_rd_addr <= rd_addr;
      end
      case (r_state)
        ST_IDLE: begin
          // In IDLE rd_busy means a read is waiting to be issued
          if (!w_fifo_empty && (!r_rd_busy || (w_fifo_count >= LP_HALF))) begin
            r_state       <= ST_WR;
            r_inb_write   <= 1'b1;
            r_inb_address <= w_fifo_head[LP_FW-1:P_DATA_NBIT];
            r_inb_wdata   <= w_fifo_head[P_DATA_NBIT-1:0];
          end else if (r_rd_busy) begin
            r_state       <= ST_RD;
            r_inb_read    <= 1'b1;
            r_inb_address <= r_rd_addr;
          end
        end
        ST_WR: begin
          if (inb.initdone) begin
            r_inb_write <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (inb.initdone) begin
            r_inb_read <= 1'b0;
            r_state    <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (inb.datavalid) begin
            r_rd_data  <= inb.rdata;
            r_rd_valid <= 1'b1;
            r_rd_busy  <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cap_busy    = r_cap_busy;
  assign cap_done    = r_cap_done;
  assign cap_ovf     = r_cap_ovf;
  assign rd_busy     = r_rd_busy;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign inb.address = r_inb_address;
  assign inb.write   = r_inb_write;
  assign inb.wdata   = r_inb_wdata;
  assign inb.read    = r_inb_read;
endmodule

// File: tb/tb_adc_capture_memctrl.sv
// Self-checking bench for adc_capture_memctrl: directed scenarios plus random
// captures, checked against a sample-index/queue reference model.
module tb_adc_capture_memctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_start = 1'b0;
  logic [15:0] cap_base = '0;
  logic [15:0] cap_len = '0;
  logic        smp_valid = 1'b0;
  logic [31:0] smp_data = '0;
  logic        cap_busy, cap_done, cap_ovf;
  logic        rd_req = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        rd_busy, rd_valid;
  logic [31:0] rd_data;

  adc_capture_memctrl_if #(.P_DATA_NBIT(32), .P_ADDR_NBIT(16)) inb_if ();

  adc_capture_memctrl #(
    .P_DATA_NBIT (32),
    .P_ADDR_NBIT (16),
    .P_FIFO_ABIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_start (cap_start),
    .cap_base  (cap_base),
    .cap_len   (cap_len),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .cap_busy  (cap_busy),
    .cap_done  (cap_done),
    .cap_ovf   (cap_ovf),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .inb       (inb_if)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [47:0] q[$];
  logic [15:0] m_base, m_rd_addr;
  int unsigned m_len, m_idx;
  logic        m_busy, m_done, m_ovf, m_rd_busy, m_rdv, m_rd_wait;
  logic [31:0] m_rd_data;
  logic        mon_en = 1'b0, spur_en = 1'b0;
  int unsigned dv_cnt = 0, dv_delay = 3;
  logic [31:0] dv_data, next_rdata = 32'h0;
  int unsigned n_wr = 0, n_rd = 0, n_done_obs = 0, prev_qsz = 0;
  logic        prev_wr_stall = 1'b0, prev_rd_stall = 1'b0, prev_read = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        nb, nd, no, nrb, nrv, full, wr_acc;
    logic [31:0] nrd;
    logic [47:0] e;
    int unsigned qsz_pre;
    inb_if.datavalid = 1'b0;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin inb_if.datavalid = 1'b1; inb_if.rdata = dv_data; end
    end else if (spur_en && !m_rd_wait && $urandom_range(0, 15) == 0) begin
      inb_if.datavalid = 1'b1;
      inb_if.rdata     = $urandom;
    end
    qsz_pre = q.size();
    if (mon_en) begin
      chk("cap_busy", cap_busy, m_busy);
      chk("cap_done", cap_done, m_done);
      chk("cap_ovf", cap_ovf, m_ovf);
      chk("rd_busy", rd_busy, m_rd_busy);
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_data", rd_data, m_rd_data);
      if (cap_done === 1'b1) n_done_obs++;
      if (inb_if.write || inb_if.read) chk("wr_rd_excl", inb_if.write && inb_if.read, 0);
      if (prev_wr_stall) begin
        chk("wr_hold", inb_if.write, 1);
        chk("wr_addr_hold", inb_if.address, prev_addr);
        chk("wr_data_hold", inb_if.wdata, prev_wdata);
      end
      if (prev_rd_stall) begin
        chk("rd_hold", inb_if.read, 1);
        chk("rd_addr_hold", inb_if.address, prev_addr);
      end
      if (inb_if.read === 1'b1 && !prev_read) chk("rd_prio_level", prev_qsz < 8, 1);
    end
    nb = m_busy; nd = 1'b0; no = m_ovf; nrb = m_rd_busy; nrv = 1'b0; nrd = m_rd_data;
    if (rst) begin
      nb = 0; no = 0; nrb = 0; nrd = '0; m_rd_wait = 0; q.delete();
      prev_wr_stall = 0; prev_rd_stall = 0; prev_read = 0;
    end else begin
      full   = (q.size() == 16);
      wr_acc = inb_if.write && inb_if.initdone;
      if (wr_acc) begin
        n_wr++;
        chk("wr_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wr_addr", inb_if.address, e[47:32]);
          chk("wr_data", inb_if.wdata, e[31:0]);
        end
      end
      if (cap_start && !m_busy) begin
        m_base = cap_base; m_len = cap_len; m_idx = 0; no = 0;
        if (cap_len == 0) nd = 1; else nb = 1;
      end else if (m_busy) begin
        if (smp_valid && m_idx < m_len) begin
          if (full) no = 1;
          else q.push_back({m_base + 16'(m_idx), smp_data});
          m_idx++;
        end
        if (m_idx == m_len && q.size() == 0 && wr_acc) begin nb = 0; nd = 1; end
      end
      if (inb_if.datavalid && m_rd_wait) begin
        m_rd_wait = 0; nrv = 1; nrd = inb_if.rdata; nrb = 0;
      end
      if (inb_if.read && inb_if.initdone) begin
        n_rd++;
        chk("rd_expected", m_rd_busy && !m_rd_wait, 1);
        chk("rd_addr", inb_if.address, m_rd_addr);
        m_rd_wait = 1; dv_cnt = dv_delay; dv_data = next_rdata; next_rdata = $urandom;
      end
      if (rd_req && !m_rd_busy) begin nrb = 1; m_rd_addr = rd_addr; end
      prev_wr_stall = inb_if.write && !inb_if.initdone;
      prev_rd_stall = inb_if.read && !inb_if.initdone;
      prev_read     = inb_if.read;
      prev_addr     = inb_if.address;
      prev_wdata    = inb_if.wdata;
    end
    prev_qsz = qsz_pre;
    @(posedge clk);
    #1;
    m_busy = nb; m_done = nd; m_ovf = no; m_rd_busy = nrb; m_rdv = nrv; m_rd_data = nrd;
    cap_start = 1'b0; rd_req = 1'b0; smp_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int unsigned budget);
    int unsigned n = 0;
    while ((m_busy || q.size() != 0 || m_rd_busy || dv_cnt != 0) && n < budget) begin
      smp_valid = m_busy;
      smp_data  = $urandom;
      tick();
      n++;
    end
    chk("quiet_timeout", n < budget, 1);
    tick();
    tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, cap_busy, 0);
    chk({tag, "_done"}, cap_done, 0);
    chk({tag, "_ovf"}, cap_ovf, 0);
    chk({tag, "_rd_busy"}, rd_busy, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_address"}, inb_if.address, 0);
    chk({tag, "_write"}, inb_if.write, 0);
    chk({tag, "_wdata"}, inb_if.wdata, 0);
    chk({tag, "_read"}, inb_if.read, 0);
  endtask

  initial begin
    int unsigned w0, d0, r0, n;
    inb_if.initdone = 1'b1; inb_if.datavalid = 1'b0; inb_if.rdata = '0;
    m_busy = 0; m_done = 0; m_ovf = 0; m_rd_busy = 0; m_rdv = 0; m_rd_wait = 0; m_rd_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero_outputs("reset");
    mon_en = 1'b1;

    // A: basic capture, write latency
    w0 = n_wr; d0 = n_done_obs;
    cap_base = 16'h00F0; cap_len = 16'd4; cap_start = 1'b1; tick();
    smp_valid = 1'b1; smp_data = 32'hA0; tick();
    smp_valid = 1'b1; smp_data = 32'hA1; tick();
    chk("A_wr_latency", inb_if.write, 1);
    chk("A_first_addr", inb_if.address, 16'h00F0);
    smp_valid = 1'b1; smp_data = 32'hA2; tick();
    smp_valid = 1'b1; smp_data = 32'hA3; tick();
    wait_quiet(100);
    chk("A_writes", n_wr - w0, 4);
    chk("A_done_pulses", n_done_obs - d0, 1);
    chk("A_ovf", cap_ovf, 0);

    // B: address wrap
    w0 = n_wr;
    cap_base = 16'hFFFE; cap_len = 16'd4; cap_start = 1'b1; tick();
    wait_quiet(100);
    chk("B_writes", n_wr - w0, 4);

    // C: stalled bridge, overflow with skipped addresses
    w0 = n_wr; d0 = n_done_obs;
    inb_if.initdone = 1'b0;
    cap_base = 16'h0100; cap_len = 16'd20; cap_start = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin smp_valid = 1'b1; smp_data = $urandom; tick(); end
    for (int i = 0; i < 19; i++) tick();
    chk("C_ovf", cap_ovf, 1);
    inb_if.initdone = 1'b1;
    wait_quiet(200);
    chk("C_writes", n_wr - w0, 16);
    chk("C_done_pulses", n_done_obs - d0, 1);

    // D: idle host read
    dv_delay = 3; next_rdata = 32'hDEADBEEF;
    rd_addr = 16'h1234; rd_req = 1'b1; tick();
    tick();
    chk("D_rd_latency", inb_if.read, 1);
    chk("D_rd_addr", inb_if.address, 16'h1234);
    wait_quiet(50);
    chk("D_rd_data", rd_data, 32'hDEADBEEF);

    // E: read while FIFO at or above half full
    inb_if.initdone = 1'b0;
    cap_base = 16'h2000; cap_len = 16'd12; cap_start = 1'b1; tick();
    for (int i = 0; i < 12; i++) begin smp_valid = 1'b1; smp_data = $urandom; tick(); end
    rd_addr = 16'h0BAD; rd_req = 1'b1; tick();
    tick();
    inb_if.initdone = 1'b1;
    w0 = n_wr; r0 = n_rd; n = 0;
    while (n_rd == r0 && n < 60) begin tick(); n++; end
    chk("E_rd_issued", n < 60, 1);
    chk("E_writes_before_read", n_wr - w0, 5);
    wait_quiet(100);

    // F: reset while waiting for read data
    dv_delay = 6;
    cap_base = 16'h3000; cap_len = 16'd10; cap_start = 1'b1;
    rd_addr = 16'h0042; rd_req = 1'b1; tick();
    n = 0;
    while (!m_rd_wait && n < 40) begin smp_valid = 1'b1; smp_data = $urandom; tick(); n++; end
    chk("F_rd_issued", n < 40, 1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zero_outputs("F_reset");
    for (int i = 0; i < 10; i++) tick();
    chk("F_no_late_rd_valid", rd_busy, 0);

    // random captures with random stalls, reads and spurious datavalid
    spur_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cap_base = 16'($urandom); cap_len = 16'($urandom_range(0, 24)); cap_start = 1'b1;
      dv_delay = $urandom_range(1, 5);
      if ($urandom_range(0, 2) == 0) begin rd_req = 1'b1; rd_addr = 16'($urandom); end
      tick();
      for (int c = 0; c < 60; c++) begin
        smp_valid = ($urandom_range(0, 3) != 0);
        smp_data  = $urandom;
        inb_if.initdone = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) begin rd_req = 1'b1; rd_addr = 16'($urandom); end
        if ($urandom_range(0, 29) == 0) cap_start = 1'b1;
        tick();
      end
      inb_if.initdone = 1'b1;
      spur_en = 1'b0;
      wait_quiet(400);
      spur_en = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
